adc_seq_ctrl: RTL and testbench

ADC_SEQ_CTRL -- requirements
Module: adc_seq_ctrl

---
 rtl/adc_pkg.sv | 16 +
 rtl/adc_tick_div.sv | 30 +++
 rtl/adc_seq_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_adc_seq_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// Shared definitions for the ADC scan sequencer: default sizes and the FSM state encoding.
package adc_pkg;

  localparam int DIV_W_DEFAULT  = 14;
  localparam int DATA_W_DEFAULT = 12;
  localparam int NUM_CH_DEFAULT = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_CONV,
    ST_STORE,
    ST_GAP
  } adc_state_e;

endpackage

// File: rtl/adc_tick_div.sv
// Tick divider: counts 0..div_val and emits a one-clk tick on each wrap while enabled.
import adc_pkg::*;

module adc_tick_div #(
  parameter int DIV_W = DIV_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [DIV_W-1:0] div_val,
  input  logic             en,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  // Disabling the divider parks it at zero so the next enabled period is a full tick.
  always_comb begin
    cnt_d = cnt_q;
    if (!en || (cnt_q == div_val)) cnt_d = '0;
    else                           cnt_d = cnt_q + 1'b1;
  end

  assign tick = en && (cnt_q == div_val);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/adc_seq_ctrl.sv
// Multi-channel serial ADC scan sequencer. Optional ADC_OVERRUN_DROP_EN makes STORE
// overwrite an unaccepted result and raise a sticky overrun flag instead of stalling.
import adc_pkg::*;

module adc_seq_ctrl #(
  parameter  int DIV_W  = DIV_W_DEFAULT,
  parameter  int DATA_W = DATA_W_DEFAULT,
  parameter  int NUM_CH = NUM_CH_DEFAULT,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              cont,
  input  logic [DIV_W-1:0]  div_val,
  input  logic [NUM_CH-1:0] ch_mask,
  output logic              adc_clk,
  output logic              adc_cs_n,
  output logic [CH_W-1:0]   adc_ch,
  input  logic              adc_dout,
  output logic [DATA_W-1:0] samp_data,
  output logic [CH_W-1:0]   samp_ch,
  output logic              samp_valid,
  input  logic              samp_ready,
  output logic              busy
`ifdef ADC_OVERRUN_DROP_EN
  ,
  output logic              overrun
`endif
);

  localparam int BC_W = $clog2(DATA_W + 1);

  adc_state_e        state_q, state_d;
  logic [CH_W-1:0]   adc_ch_q, adc_ch_d;
  logic              adc_clk_q, adc_clk_d;
  logic              cs_n_q, cs_n_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] samp_data_q, samp_data_d;
  logic [CH_W-1:0]   samp_ch_q, samp_ch_d;
  logic              samp_valid_q, samp_valid_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic [DIV_W-1:0]  div_val_q, div_val_d;
  logic [NUM_CH-1:0] above;
  logic              tick;
`ifdef ADC_OVERRUN_DROP_EN
  logic              overrun_q, overrun_d;
`endif

  function automatic logic [CH_W-1:0] lowest_set(input logic [NUM_CH-1:0] m);
    lowest_set = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (m[i]) lowest_set = CH_W'(i);
  endfunction

  function automatic logic [NUM_CH-1:0] bits_above(input logic [NUM_CH-1:0] m,
                                                   input logic [CH_W-1:0]   ch);
    bits_above = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (i > int'(ch)) bits_above[i] = m[i];
  endfunction

  // Held idle in STORE so the GAP that follows always lasts one full tick.
  adc_tick_div #(.DIV_W(DIV_W)) u_tick_div (
    .clk     (clk),
    .reset_n (reset_n),
    .div_val (div_val_q),
    .en      ((state_q != ST_IDLE) && (state_q != ST_STORE)),
    .tick    (tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      adc_ch_q     <= '0;
      adc_clk_q    <= 1'b0;
      cs_n_q       <= 1'b1;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      samp_data_q  <= '0;
      samp_ch_q    <= '0;
      samp_valid_q <= 1'b0;
      mask_q       <= '0;
      div_val_q    <= '0;
`ifdef ADC_OVERRUN_DROP_EN
      overrun_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      adc_ch_q     <= adc_ch_d;
      adc_clk_q    <= adc_clk_d;
      cs_n_q       <= cs_n_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      samp_data_q  <= samp_data_d;
      samp_ch_q    <= samp_ch_d;
      samp_valid_q <= samp_valid_d;
      mask_q       <= mask_d;
      div_val_q    <= div_val_d;
`ifdef ADC_OVERRUN_DROP_EN
      overrun_q    <= overrun_d;
`endif
    end
  end

  assign above = bits_above(mask_q, adc_ch_q);

  always_comb begin
    state_d      = state_q;
    adc_ch_d     = adc_ch_q;
    adc_clk_d    = adc_clk_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    samp_data_d  = samp_data_q;
    samp_ch_d    = samp_ch_q;
    samp_valid_d = samp_valid_q;
    mask_d       = mask_q;
    div_val_d    = div_val_q;
`ifdef ADC_OVERRUN_DROP_EN
    overrun_d    = overrun_q;
`endif
    if (samp_valid_q && samp_ready) samp_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && (|ch_mask)) begin
          state_d   = ST_SETUP;
          mask_d    = ch_mask;
          div_val_d = div_val;
          adc_ch_d  = lowest_set(ch_mask);
        end
      end
      ST_SETUP: begin
        if (tick) begin
          state_d   = ST_CONV;
          shift_d   = '0;
          bit_cnt_d = '0;
        end
      end
      ST_CONV: begin
        if (tick) begin
          if (adc_clk_q) begin
            adc_clk_d = 1'b0;
            if (bit_cnt_q == BC_W'(DATA_W)) state_d = ST_STORE;
          end else begin
            adc_clk_d = 1'b1;
            shift_d   = {shift_q[DATA_W-2:0], adc_dout};
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      ST_STORE: begin
`ifdef ADC_OVERRUN_DROP_EN
        if (samp_valid_q && !samp_ready) overrun_d = 1'b1;
        samp_data_d  = shift_q;
        samp_ch_d    = adc_ch_q;
        samp_valid_d = 1'b1;
        state_d      = ST_GAP;
`else
        if (!samp_valid_q || samp_ready) begin
          samp_data_d  = shift_q;
          samp_ch_d    = adc_ch_q;
          samp_valid_d = 1'b1;
          state_d      = ST_GAP;
        end
`endif
      end
      ST_GAP: begin
        if (tick) begin
          if (|above) begin
            state_d  = ST_SETUP;
            adc_ch_d = lowest_set(above);
          end else if (cont) begin
            state_d  = ST_SETUP;
            adc_ch_d = lowest_set(mask_q);
          end else begin
            state_d  = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Chip select is registered from the next state so it cannot glitch off-chip.
  always_comb begin
    busy   = (state_q != ST_IDLE);
    cs_n_d = 1'b1;
    if ((state_d == ST_SETUP) || (state_d == ST_CONV) || (state_d == ST_STORE)) cs_n_d = 1'b0;
  end

  assign adc_clk    = adc_clk_q;
  assign adc_cs_n   = cs_n_q;
  assign adc_ch     = adc_ch_q;
  assign samp_data  = samp_data_q;
  assign samp_ch    = samp_ch_q;
  assign samp_valid = samp_valid_q;
`ifdef ADC_OVERRUN_DROP_EN
  assign overrun    = overrun_q;
`endif

endmodule

// File: tb/tb_adc_seq_ctrl.sv
// Self-checking bench for adc_seq_ctrl: a behavioural ADC drives random words per frame,
// and a queue-based model predicts channel order and the results the consumer receives.
module tb_adc_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        cont;
  logic [13:0] div_val;
  logic [3:0]  ch_mask;
  logic        adc_clk;
  logic        adc_cs_n;
  logic [1:0]  adc_ch;
  logic        adc_dout = 1'b0;
  logic [11:0] samp_data;
  logic [1:0]  samp_ch;
  logic        samp_valid;
  logic        samp_ready = 1'b0;
  logic        busy;
`ifdef ADC_OVERRUN_DROP_EN
  logic        overrun;
`endif

  int vecCount  = 0;
  int missCount = 0;

  int          readyMode   = 1;
  bit          monOn       = 1'b0;
  bit          scoreOn     = 1'b0;
  bit          fixedWordEn = 1'b0;
  logic [11:0] fixedWord   = 12'h000;
  int          divExp      = 0;

  logic        prevCs      = 1'b1;
  logic        prevAclk    = 1'b0;
  int          bitIdx      = 0;
  int          cycSinceRise = 0;
  logic [11:0] curWord     = 12'h000;
  int          frameChs[$];
  int          expSeq[$];
  logic [13:0] expQ[$];

  always #5 clk = ~clk;

  adc_seq_ctrl #(.DIV_W(14), .DATA_W(12), .NUM_CH(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .cont       (cont),
    .div_val    (div_val),
    .ch_mask    (ch_mask),
    .adc_clk    (adc_clk),
    .adc_cs_n   (adc_cs_n),
    .adc_ch     (adc_ch),
    .adc_dout   (adc_dout),
    .samp_data  (samp_data),
    .samp_ch    (samp_ch),
    .samp_valid (samp_valid),
    .samp_ready (samp_ready),
    .busy       (busy)
`ifdef ADC_OVERRUN_DROP_EN
    ,
    .overrun    (overrun)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecCount++;
    if (got !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ADC model, consumer and scoreboard all act on the falling clk edge.
  always @(negedge clk) begin
    logic [13:0] e;
    int          idx;
    if (!monOn) begin
      samp_ready = 1'b0;
      adc_dout   = 1'b0;
    end else begin
      case (readyMode)
        0:       samp_ready = 1'b0;
        1:       samp_ready = 1'b1;
        default: samp_ready = 1'($urandom_range(0, 1));
      endcase
      cycSinceRise++;
      if (prevCs && !adc_cs_n) begin
        frameChs.push_back(int'(adc_ch));
        curWord = fixedWordEn ? fixedWord : 12'($urandom);
        expQ.push_back({adc_ch, curWord});
        bitIdx = 0;
      end
      if (!prevCs && adc_cs_n) begin
        checkOutput("bitsPerFrame", bitIdx, 12);
        checkOutput("clkLowAtCsHigh", adc_clk, 0);
      end
      if (adc_clk && !prevAclk) begin
        if (bitIdx > 0) checkOutput("aclkPeriod", cycSinceRise, 2 * (divExp + 1));
        cycSinceRise = 0;
        bitIdx++;
      end
      idx = 11 - bitIdx;
      adc_dout = (bitIdx < 12) ? curWord[idx] : 1'b0;
      if (scoreOn && samp_valid && samp_ready) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpectedResult", 1, 0);
        end else begin
          e = expQ.pop_front();
          checkOutput("sampData", samp_data, e[11:0]);
          checkOutput("sampCh", samp_ch, e[13:12]);
        end
      end
    end
    prevCs   = adc_cs_n;
    prevAclk = adc_clk;
  end

  task automatic applyStimulus(input logic [13:0] dv, input logic [3:0] mask, input logic c);
    @(negedge clk);
    div_val = dv;
    ch_mask = mask;
    cont    = c;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  // Expected channel order: ascending set bits, repeated once per pass.
  task automatic modelScan(input logic [3:0] mask, input int passes);
    for (int p = 0; p < passes; p++)
      for (int c = 0; c < 4; c++)
        if (mask[c]) expSeq.push_back(c);
  endtask

  task automatic waitIdle(input int maxCycles);
    int n = 0;
    while (busy && n < maxCycles) begin
      @(negedge clk);
      n++;
    end
    if (busy) checkOutput("idleTimeout", 1, 0);
  endtask

  task automatic waitFrames(input int count, input int maxCycles);
    int n = 0;
    while (frameChs.size() < count && n < maxCycles) begin
      @(negedge clk);
      n++;
    end
    if (frameChs.size() < count) checkOutput("frameTimeout", frameChs.size(), count);
  endtask

  task automatic checkSeq();
    checkOutput("frameCount", frameChs.size(), expSeq.size());
    for (int i = 0; i < frameChs.size() && i < expSeq.size(); i++)
      checkOutput("frameCh", frameChs[i], expSeq[i]);
    frameChs.delete();
    expSeq.delete();
  endtask

  task automatic drainCheck();
    readyMode = 1;
    repeat (4) @(negedge clk);
    checkOutput("drained", expQ.size(), 0);
    checkOutput("validClear", samp_valid, 0);
  endtask

  initial begin
    logic [3:0]  m;
    logic [13:0] dv;
    logic [13:0] e;
    int          validSeen;

    reset_n = 1'b0; start = 1'b0; cont = 1'b0; div_val = '0; ch_mask = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstCsN", adc_cs_n, 1);
    checkOutput("rstAclk", adc_clk, 0);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstValid", samp_valid, 0);
    checkOutput("rstData", samp_data, 0);
    checkOutput("rstSampCh", samp_ch, 0);
    checkOutput("rstAdcCh", adc_ch, 0);
`ifdef ADC_OVERRUN_DROP_EN
    checkOutput("rstOverrun", overrun, 0);
`endif
    @(negedge clk);
    reset_n = 1'b1;
    monOn = 1'b1; scoreOn = 1'b1;

    $display("[TB] single channel, fixed word 0xA5C");
    fixedWordEn = 1'b1; fixedWord = 12'hA5C; readyMode = 1; divExp = 3;
    applyStimulus(14'd3, 4'b0001, 1'b0);
    modelScan(4'b0001, 1);
    waitIdle(5000);
    checkSeq();
    checkOutput("req035Data", samp_data, 12'hA5C);
    checkOutput("req035Ch", samp_ch, 0);
    drainCheck();
    fixedWordEn = 1'b0;

    $display("[TB] mask 1010 single pass");
    divExp = 1;
    applyStimulus(14'd1, 4'b1010, 1'b0);
    modelScan(4'b1010, 1);
    waitIdle(5000);
    checkSeq();
    checkOutput("idleBusy", busy, 0);
    drainCheck();

    $display("[TB] continuous scan, cont dropped during channel 0");
    divExp = 1;
    applyStimulus(14'd1, 4'b1001, 1'b1);
    modelScan(4'b1001, 3);
    waitFrames(5, 5000);
    cont = 1'b0;
    waitIdle(5000);
    checkSeq();
    drainCheck();

    $display("[TB] randomized scans with random ready");
    for (int t = 0; t < 6; t++) begin
      m  = 4'($urandom_range(1, 15));
      dv = 14'($urandom_range(0, 3));
      divExp = int'(dv);
      readyMode = 2;
      applyStimulus(dv, m, 1'b0);
      modelScan(m, 1);
      waitIdle(8000);
      checkSeq();
      drainCheck();
    end

    $display("[TB] ignored starts");
    applyStimulus(14'd0, 4'b0000, 1'b0);
    repeat (10) @(negedge clk);
    checkOutput("maskZeroBusy", busy, 0);
    checkOutput("maskZeroCs", adc_cs_n, 1);
    checkOutput("maskZeroFrames", frameChs.size(), 0);
    divExp = 2;
    applyStimulus(14'd2, 4'b0001, 1'b0);
    modelScan(4'b0001, 1);
    repeat (20) @(negedge clk);
    applyStimulus(14'd0, 4'b1110, 1'b0);
    waitIdle(5000);
    checkSeq();
    drainCheck();

    $display("[TB] consumer stall with two channels");
    readyMode = 0; divExp = 0;
`ifdef ADC_OVERRUN_DROP_EN
    scoreOn = 1'b0;
`endif
    applyStimulus(14'd0, 4'b0011, 1'b0);
    modelScan(4'b0011, 1);
    repeat (150) @(negedge clk);
    checkOutput("stallValid", samp_valid, 1);
`ifdef ADC_OVERRUN_DROP_EN
    e = (expQ.size() > 1) ? expQ[1] : 14'h0;
    checkOutput("dropBusy", busy, 0);
    checkOutput("dropData", samp_data, e[11:0]);
    checkOutput("dropCh", samp_ch, 1);
    checkOutput("overrun", overrun, 1);
    readyMode = 1;
    repeat (4) @(negedge clk);
    expQ.delete();
    scoreOn = 1'b1;
`else
    e = (expQ.size() > 0) ? expQ[0] : 14'h0;
    checkOutput("stallBusy", busy, 1);
    checkOutput("stallCsLow", adc_cs_n, 0);
    checkOutput("stallHeldData", samp_data, e[11:0]);
    checkOutput("stallHeldCh", samp_ch, 0);
    readyMode = 1;
    waitIdle(5000);
`endif
    checkSeq();
    drainCheck();

    $display("[TB] reset during conversion");
    readyMode = 0; divExp = 1;
    applyStimulus(14'd1, 4'b0101, 1'b0);
    waitFrames(2, 5000);
    repeat (20) @(negedge clk);
    checkOutput("validBeforeReset", samp_valid, 1);
    monOn = 1'b0;
    reset_n = 1'b0;
    #1;
    checkOutput("midRstCs", adc_cs_n, 1);
    checkOutput("midRstAclk", adc_clk, 0);
    checkOutput("midRstValid", samp_valid, 0);
    checkOutput("midRstBusy", busy, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    validSeen = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (samp_valid || busy) validSeen++;
    end
    checkOutput("noActivityAfterReset", validSeen, 0);
    frameChs.delete();
    expQ.delete();

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
